// File: rtl/enc_layer_sched_pkg.sv
// Shared definitions for the time-multiplexed dense encoder layer sequencer.
// Holds the FSM state encoding and the ROM map helper. The saturation
// constant lives beside the adder in sm_accumulate because its width follows
// that module's word-width parameter.
package enc_layer_sched_pkg;

  // FSM state encoding (3-bit constants)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_BIAS  = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  // ROM map: all weights first (row-major o*N_IN+i), biases start right after.
  function automatic int bias_base(input int n_in, input int n_out);
    return n_in * n_out;
  endfunction

endpackage

// File: rtl/enc_layer_sched_sm_accumulate.sv
// Combinational sign-magnitude adder used for both product accumulation and
// the final bias add. Compile-time option: ACC_SAT_EN clamps an overflowing
// magnitude to all-ones (sign kept); without it the magnitude carry is dropped.
module sm_accumulate #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] addend_i,
  output logic [W-1:0] sum_o
);

  localparam int MW = W - 1;

`ifdef ACC_SAT_EN
  localparam logic [MW-1:0] SM_MAX = '1;
  logic [MW:0] add_wide;
`endif

  logic          sa;
  logic          sb;
  logic [MW-1:0] ma;
  logic [MW-1:0] mb;
  logic [MW-1:0] mag;
  logic          sgn;

  // Sign-magnitude add: like signs add magnitudes, unlike signs subtract the
  // smaller from the larger; a zero magnitude always comes out as +0.
  always_comb begin
    sa  = acc_i[W-1];
    sb  = addend_i[W-1];
    ma  = acc_i[MW-1:0];
    mb  = addend_i[MW-1:0];
    mag = '0;
    sgn = 1'b0;
`ifdef ACC_SAT_EN
    add_wide = '0;
`endif
    if (sa == sb) begin
`ifdef ACC_SAT_EN
      add_wide = {1'b0, ma} + {1'b0, mb};
      mag      = add_wide[MW] ? SM_MAX : add_wide[MW-1:0];
`else
      mag      = ma + mb;
`endif
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == '0) begin
      sgn = 1'b0;
    end
    sum_o = {sgn, mag};
  end

endmodule

// File: rtl/enc_layer_sched.sv
// Time-multiplexed sequencer for one dense encoder layer:
//   y[o] = b[o] + sum_i w[o][i]*x[i]   (sign-magnitude words)
// One external multiplier (fixed latency MUL_LAT, products already rescaled)
// and one synchronous weight/bias ROM port (data one cycle after rom_en).
// Compile-time option: ACC_SAT_EN selects saturating accumulation (see
// sm_accumulate); the default build wraps the magnitude.
module enc_layer_sched
  import enc_layer_sched_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6,
  parameter int MUL_LAT = 2,
  parameter int AW      = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [BITSIZE*N_IN-1:0]  x,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            rom_addr,
  output logic                     rom_en,
  input  logic [BITSIZE-1:0]       rom_data,
  output logic [BITSIZE-1:0]       mul_a,
  output logic [BITSIZE-1:0]       mul_b,
  output logic                     mul_valid,
  input  logic [BITSIZE-1:0]       mul_p,
  input  logic                     mul_p_valid,
  output logic [BITSIZE-1:0]       acc_out,
  output logic [2:0]               acc_idx,
  output logic                     acc_valid,
  output logic [BITSIZE*N_OUT-1:0] y
);

  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int DW  = $clog2(MUL_LAT + 2) + 1;
  localparam int OCW = $clog2(N_IN + MUL_LAT + 4) + 1;

  localparam logic [IW-1:0] I_LAST    = IW'(N_IN - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(MUL_LAT + 1);
  localparam logic [2:0]    O_LAST    = 3'(N_OUT - 1);
  localparam logic [AW-1:0] BIAS_BASE = AW'(bias_base(N_IN, N_OUT));

  // Sequencer state and counters
  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      i_q, i_d;
  logic [2:0]         o_q, o_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [OCW-1:0]     out_cnt_q, out_cnt_d;
  logic               latch_x;

  // Datapath
  logic [BITSIZE-1:0] acc_q;
  logic [BITSIZE-1:0] addend;
  logic [BITSIZE-1:0] acc_sum;
  logic               issue;
  logic               acc_take;

  // ROM-return to multiplier-operand pipeline
  logic               rd_pend_q;
  logic [IW-1:0]      rd_idx_q;
  logic               mul_valid_q;
  logic [BITSIZE-1:0] mul_a_q;
  logic [BITSIZE-1:0] mul_b_q;

  // Streamed neuron result
  logic               acc_valid_q;
  logic [BITSIZE-1:0] acc_out_q;
  logic [2:0]         acc_idx_q;

  logic [BITSIZE-1:0] x_lat [N_IN];

  // A weight read goes out every FETCH cycle; products are only expected back
  // while fetching or draining, anything else (e.g. stragglers after an abort)
  // is dropped.
  assign issue    = (state_q == ST_FETCH);
  assign acc_take = mul_p_valid && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));

  // The shared adder sees the multiplier product normally and the bias word
  // (returned by the ROM) in EMIT.
  assign addend = (state_q == ST_EMIT) ? rom_data : mul_p;

  sm_accumulate #(
    .W(BITSIZE)
  ) u_sm_add (
    .acc_i   (acc_q),
    .addend_i(addend),
    .sum_o   (acc_sum)
  );

  // Outstanding product bookkeeping: one in per weight read, one out per product.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue && !acc_take) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end else if (!issue && acc_take) begin
      out_cnt_d = out_cnt_q - 1'b1;
    end
  end

  // Next-state logic for the per-neuron FETCH/DRAIN/BIAS/EMIT cycle.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    o_d     = o_q;
    drain_d = drain_q;
    waddr_d = waddr_q;
    latch_x = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          i_d     = '0;
          o_d     = '0;
          drain_d = '0;
          waddr_d = '0;
          latch_x = 1'b1;
        end
      end
      ST_FETCH: begin
        // Weight addresses run contiguously across neurons (o*N_IN+i).
        waddr_d = waddr_q + 1'b1;
        if (i_q == I_LAST) begin
          state_d = ST_DRAIN;
          i_d     = '0;
          drain_d = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Fixed length covers ROM + operand register + multiplier latency;
        // the outstanding count confirms nothing is still in flight.
        if (drain_q == D_LAST) begin
          if (out_cnt_d == '0) begin
            state_d = ST_BIAS;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_BIAS: begin
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (o_q == O_LAST) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_FETCH;
          o_d     = o_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      o_q       <= '0;
      drain_q   <= '0;
      waddr_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      o_q       <= o_d;
      drain_q   <= drain_d;
      waddr_q   <= waddr_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Accumulator: cleared while idle and after each neuron is emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if ((state_q == ST_IDLE) || (state_q == ST_EMIT)) begin
      acc_q <= '0;
    end else if (acc_take) begin
      acc_q <= acc_sum;
    end
  end

  // Pair each returned weight with its x element and present it to the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      rd_pend_q   <= issue;
      rd_idx_q    <= i_q;
      mul_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        mul_a_q <= x_lat[rd_idx_q];
        mul_b_q <= rom_data;
      end
    end
  end

  // Stream each finished neuron towards the activation stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_valid_q <= 1'b0;
      acc_out_q   <= '0;
      acc_idx_q   <= '0;
    end else begin
      acc_valid_q <= (state_q == ST_EMIT);
      if (state_q == ST_EMIT) begin
        acc_out_q <= acc_sum;
        acc_idx_q <= o_q;
      end
    end
  end

  genvar gi;

  // Input latch: captured only on an accepted start.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_x
      logic [BITSIZE-1:0] x_word_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          x_word_q <= '0;
        end else if (latch_x) begin
          x_word_q <= x[gi*BITSIZE +: BITSIZE];
        end
      end
      assign x_lat[gi] = x_word_q;
    end
  endgenerate

  // Output vector: each word changes only when its own neuron is emitted.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_y
      logic [BITSIZE-1:0] y_word_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          y_word_q <= '0;
        end else if ((state_q == ST_EMIT) && (o_q == 3'(gi))) begin
          y_word_q <= acc_sum;
        end
      end
      assign y[gi*BITSIZE +: BITSIZE] = y_word_q;
    end
  endgenerate

  // ROM port: weights during FETCH, this neuron's bias during BIAS.
  always_comb begin
    rom_addr = '0;
    if (state_q == ST_FETCH) begin
      rom_addr = waddr_q;
    end else if (state_q == ST_BIAS) begin
      rom_addr = BIAS_BASE + AW'(o_q);
    end
  end

  assign rom_en    = (state_q == ST_FETCH) || (state_q == ST_BIAS);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                     (state_q == ST_BIAS)  || (state_q == ST_EMIT);
  assign done      = (state_q == ST_FIN);
  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign acc_valid = acc_valid_q;
  assign acc_out   = acc_out_q;
  assign acc_idx   = acc_idx_q;

endmodule

// File: tb/tb_enc_layer_sched.sv
// Self-checking bench for enc_layer_sched: ROM and multiplier models around
// the DUT, a plain-arithmetic reference for the layer, directed cases and
// randomized evaluations.
module tb_enc_layer_sched;

  localparam int BITSIZE  = 16;
  localparam int N_IN     = 10;
  localparam int N_OUT    = 6;
  localparam int FRAC     = 8;
  localparam int MUL_LAT  = 2;
  localparam int AW       = 7;
  localparam int DONE_LAT = N_OUT * (N_IN + MUL_LAT + 4) + 1;
  localparam int TIMEOUT  = 400;
  localparam int MAXMAG   = (1 << (BITSIZE - 1)) - 1;
  localparam int BBASE    = N_IN * N_OUT;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [BITSIZE*N_IN-1:0]  x;
  logic                     busy;
  logic                     done;
  logic [AW-1:0]            rom_addr;
  logic                     rom_en;
  logic [BITSIZE-1:0]       rom_data;
  logic [BITSIZE-1:0]       mul_a;
  logic [BITSIZE-1:0]       mul_b;
  logic                     mul_valid;
  logic [BITSIZE-1:0]       mul_p;
  logic                     mul_p_valid;
  logic [BITSIZE-1:0]       acc_out;
  logic [2:0]               acc_idx;
  logic                     acc_valid;
  logic [BITSIZE*N_OUT-1:0] y;

  int vec_cnt = 0;
  int mis_cnt = 0;

  logic [BITSIZE-1:0] rom_mem [1 << AW];
  logic [BITSIZE-1:0] xm      [N_IN];
  logic [BITSIZE-1:0] exp_y   [N_OUT];
  logic               pv_pipe [MUL_LAT];
  logic [BITSIZE-1:0] pp_pipe [MUL_LAT];

  int addr_q[$];
  int idx_q[$];
  int val_q[$];

  enc_layer_sched #(
    .BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT), .MUL_LAT(MUL_LAT), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_p(mul_p), .mul_p_valid(mul_p_valid),
    .acc_out(acc_out), .acc_idx(acc_idx), .acc_valid(acc_valid), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign-magnitude product, rescaled by FRAC, magnitude clamped (external multiplier behaviour).
  function automatic logic [BITSIZE-1:0] sm_mul(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
    longint m;
    logic   sg;
    logic [BITSIZE-1:0] r;
    m = (longint'(a[BITSIZE-2:0]) * longint'(b[BITSIZE-2:0])) >> FRAC;
    if (m > MAXMAG) m = MAXMAG;
    sg = a[BITSIZE-1] ^ b[BITSIZE-1];
    if (m == 0) sg = 1'b0;
    r = {sg, m[BITSIZE-2:0]};
    return r;
  endfunction

  // Reference add on plain signed integers.
  function automatic logic [BITSIZE-1:0] sm_add_ref(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] b);
    longint va, vb, s, m;
    logic   sg;
    logic [BITSIZE-1:0] r;
    va = a[BITSIZE-1] ? -longint'(a[BITSIZE-2:0]) : longint'(a[BITSIZE-2:0]);
    vb = b[BITSIZE-1] ? -longint'(b[BITSIZE-2:0]) : longint'(b[BITSIZE-2:0]);
    s  = va + vb;
    sg = (s < 0);
    m  = sg ? -s : s;
`ifdef ACC_SAT_EN
    if (m > MAXMAG) m = MAXMAG;
`else
    m = m % (MAXMAG + 1);
`endif
    if (m == 0) sg = 1'b0;
    r = {sg, m[BITSIZE-2:0]};
    return r;
  endfunction

  // Synchronous ROM: data one cycle after rom_en.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_mem[rom_addr];
  end

  // Fixed-latency multiplier; deliberately not reset by the DUT reset.
  initial begin
    for (int k = 0; k < MUL_LAT; k++) begin
      pv_pipe[k] = 1'b0;
      pp_pipe[k] = '0;
    end
  end
  always @(posedge clk) begin
    pv_pipe[0] <= mul_valid;
    pp_pipe[0] <= sm_mul(mul_a, mul_b);
    for (int k = 1; k < MUL_LAT; k++) begin
      pv_pipe[k] <= pv_pipe[k-1];
      pp_pipe[k] <= pp_pipe[k-1];
    end
  end
  assign mul_p_valid = pv_pipe[MUL_LAT-1];
  assign mul_p       = pp_pipe[MUL_LAT-1];

  // Record ROM reads and streamed results away from the active edge.
  always @(negedge clk) begin
    if (rom_en) addr_q.push_back(int'(rom_addr));
    if (acc_valid) begin
      idx_q.push_back(int'(acc_idx));
      val_q.push_back(int'(acc_out));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BITSIZE-1:0] y_word(input int o);
    logic [BITSIZE*N_OUT-1:0] v;
    v = y;
    return v[o*BITSIZE +: BITSIZE];
  endfunction

  function automatic logic [BITSIZE*N_IN-1:0] pack_x();
    logic [BITSIZE*N_IN-1:0] v;
    v = '0;
    for (int i = 0; i < N_IN; i++) v[i*BITSIZE +: BITSIZE] = xm[i];
    return v;
  endfunction

  // Layer reference: dot product in order, then the bias.
  task automatic compute_expected();
    logic [BITSIZE-1:0] acc;
    for (int o = 0; o < N_OUT; o++) begin
      acc = '0;
      for (int i = 0; i < N_IN; i++) acc = sm_add_ref(acc, sm_mul(xm[i], rom_mem[o*N_IN+i]));
      exp_y[o] = sm_add_ref(acc, rom_mem[BBASE+o]);
    end
  endtask

  function automatic logic [BITSIZE-1:0] rand_word();
    logic [BITSIZE-1:0] w;
    w = BITSIZE'($urandom);
    w[BITSIZE-2:0] = w[BITSIZE-2:0] >> $urandom_range(0, 7);
    return w;
  endfunction

  // One full evaluation from an idle DUT, checked against the reference.
  task automatic do_eval(input string tag);
    int cyc;
    int busy_cnt;
    int n;
    int exp_addr[$];
    compute_expected();
    addr_q.delete();
    idx_q.delete();
    val_q.delete();
    @(negedge clk);
    x     = pack_x();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < TIMEOUT) begin
      busy_cnt += int'(busy);
      @(negedge clk);
      cyc++;
    end
    #1;
    check_val({tag, ".done_lat"}, cyc, DONE_LAT);
    check_val({tag, ".busy_cycles"}, busy_cnt, DONE_LAT - 1);
    check_val({tag, ".busy_at_done"}, {31'd0, busy}, 0);
    for (int o = 0; o < N_OUT; o++)
      check_val($sformatf("%s.y[%0d]", tag, o), y_word(o), exp_y[o]);
    check_val({tag, ".acc_valid_cnt"}, idx_q.size(), N_OUT);
    n = (idx_q.size() < N_OUT) ? idx_q.size() : N_OUT;
    for (int o = 0; o < n; o++) begin
      check_val($sformatf("%s.acc_idx[%0d]", tag, o), idx_q[o], o);
      check_val($sformatf("%s.acc_out[%0d]", tag, o), val_q[o], int'(exp_y[o]));
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) exp_addr.push_back(o*N_IN + i);
      exp_addr.push_back(BBASE + o);
    end
    check_val({tag, ".rom_reads"}, addr_q.size(), exp_addr.size());
    n = (addr_q.size() < exp_addr.size()) ? addr_q.size() : exp_addr.size();
    for (int j = 0; j < n; j++)
      check_val($sformatf("%s.rom_addr[%0d]", tag, j), addr_q[j], exp_addr[j]);
  endtask

  initial begin
    logic [BITSIZE*N_IN-1:0] xa_bus, xb_bus;
    logic [BITSIZE-1:0] exp_a [N_OUT];
    logic [BITSIZE-1:0] exp_b [N_OUT];
    int done_k[$];
    int low_cnt;
    int done_cnt;
    int k;

    reset = 1'b1;
    start = 1'b0;
    x     = '0;
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst.busy", {31'd0, busy}, 0);
    check_val("rst.done", {31'd0, done}, 0);
    check_val("rst.rom_en", {31'd0, rom_en}, 0);
    check_val("rst.mul_valid", {31'd0, mul_valid}, 0);
    check_val("rst.acc_valid", {31'd0, acc_valid}, 0);
    for (int o = 0; o < N_OUT; o++) check_val($sformatf("rst.y[%0d]", o), y_word(o), 0);
    reset = 1'b0;
    @(negedge clk);

    // All ones: every neuron sums ten 1.0 products
    for (int i = 0; i < N_IN; i++) xm[i] = 16'h0100;
    for (int a = 0; a < BBASE; a++) rom_mem[a] = 16'h0100;
    for (int o = 0; o < N_OUT; o++) rom_mem[BBASE+o] = 16'h0000;
    do_eval("ones");
    for (int o = 0; o < N_OUT; o++) check_val($sformatf("ones.lit[%0d]", o), y_word(o), 16'h0A00);

    // Negative weight plus positive bias; zero neurons must come out +0
    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = '0;
    for (int i = 0; i < N_IN; i++) xm[i] = 16'h0100;
    xm[0] = 16'h0200;
    rom_mem[0] = 16'h8100;
    rom_mem[BBASE] = 16'h0080;
    do_eval("signs");
    check_val("signs.lit0", y_word(0), 16'h8180);
    for (int o = 1; o < N_OUT; o++) check_val($sformatf("signs.lit[%0d]", o), y_word(o), 16'h0000);

    // Overflowing accumulation
    for (int i = 0; i < N_IN; i++) xm[i] = 16'h7000;
    for (int a = 0; a < BBASE; a++) rom_mem[a] = 16'h0400;
    for (int o = 0; o < N_OUT; o++) rom_mem[BBASE+o] = 16'h0000;
    do_eval("ovf");
`ifdef ACC_SAT_EN
    for (int o = 0; o < N_OUT; o++) check_val($sformatf("ovf.sat[%0d]", o), y_word(o), 16'h7FFF);
`endif

    // Reset in the middle of an evaluation
    for (int i = 0; i < N_IN; i++) xm[i] = rand_word();
    for (int a = 0; a < BBASE + N_OUT; a++) rom_mem[a] = rand_word();
    @(negedge clk);
    x     = pack_x();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k < 40) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort.busy", {31'd0, busy}, 0);
    check_val("abort.done", {31'd0, done}, 0);
    check_val("abort.rom_en", {31'd0, rom_en}, 0);
    check_val("abort.rom_addr", {25'd0, rom_addr}, 0);
    check_val("abort.mul_valid", {31'd0, mul_valid}, 0);
    check_val("abort.mul_a", {16'd0, mul_a}, 0);
    check_val("abort.mul_b", {16'd0, mul_b}, 0);
    check_val("abort.acc_valid", {31'd0, acc_valid}, 0);
    check_val("abort.acc_out", {16'd0, acc_out}, 0);
    check_val("abort.acc_idx", {29'd0, acc_idx}, 0);
    for (int o = 0; o < N_OUT; o++) check_val($sformatf("abort.y[%0d]", o), y_word(o), 0);
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      done_cnt += int'(done);
    end
    check_val("abort.no_done", done_cnt, 0);
    for (int i = 0; i < N_IN; i++) xm[i] = rand_word();
    do_eval("after_abort");

    // start held high: back-to-back evaluations, x changes during busy ignored
    for (int i = 0; i < N_IN; i++) xm[i] = rand_word();
    compute_expected();
    xa_bus = pack_x();
    for (int o = 0; o < N_OUT; o++) exp_a[o] = exp_y[o];
    for (int i = 0; i < N_IN; i++) xm[i] = rand_word();
    compute_expected();
    xb_bus = pack_x();
    for (int o = 0; o < N_OUT; o++) exp_b[o] = exp_y[o];
    @(negedge clk);
    x     = xa_bus;
    start = 1'b1;
    low_cnt = 0;
    for (int kk = 1; kk <= 3 * (DONE_LAT + 1); kk++) begin
      @(negedge clk);
      if (kk == 20) x = xb_bus;
      if (!busy) low_cnt++;
      if (done) begin
        for (int o = 0; o < N_OUT; o++)
          check_val($sformatf("hold%0d.y[%0d]", done_k.size(), o), y_word(o),
                    (done_k.size() == 0) ? exp_a[o] : exp_b[o]);
        done_k.push_back(kk);
      end
      if (kk == 3 * (DONE_LAT + 1)) start = 1'b0;
    end
    check_val("hold.done_cnt", done_k.size(), 3);
    for (int j = 0; j < done_k.size() && j < 3; j++)
      check_val($sformatf("hold.done_at[%0d]", j), done_k[j], DONE_LAT + j * (DONE_LAT + 1));
    check_val("hold.busy_low", low_cnt, 6);

    // Randomized evaluations
    for (int e = 0; e < 200; e++) begin
      for (int i = 0; i < N_IN; i++) xm[i] = rand_word();
      for (int a = 0; a < BBASE + N_OUT; a++) rom_mem[a] = rand_word();
      do_eval($sformatf("rnd%0d", e));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
